// File: rtl/bnn_popcount_accum_pkg.sv
// Shared definitions for the BNN popcount accumulator: part/pack widths, default
// accumulator width and FSM state encodings.
package bnn_popcount_accum_pkg;

    localparam int BNN_PART_W        = 8;
    localparam int BNN_PACK_W        = 8;
    localparam int BNN_ACC_W_DEFAULT = 12;

    localparam logic [0:0] ST_ACCUM = 1'b0;
    localparam logic [0:0] ST_HOLD  = 1'b1;

endpackage

// File: rtl/bnn_popcount_accum_accum_unit.sv
// Per-neuron accumulator and sign activation. Macro BNN_ACC_SAT_EN selects a
// saturating add instead of the default modulo-2^ACC_W wrap.
module bnn_accum_unit
    import bnn_popcount_accum_pkg::*;
#(
    parameter int ACC_W = BNN_ACC_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr_i,
    input  logic                  take_i,
    input  logic                  last_i,
    input  logic [BNN_PART_W-1:0] part_i,
    input  logic [ACC_W-1:0]      thr_i,
    output logic                  act_o
);

    logic [ACC_W-1:0] acc_q;
    logic [ACC_W-1:0] acc_d;
    logic [ACC_W-1:0] part_ext;
    logic [ACC_W-1:0] sum;

    assign part_ext = ACC_W'(part_i);

`ifdef BNN_ACC_SAT_EN
    logic [ACC_W:0] sum_wide;

    // Once the add carries out, pin the running sum at full scale.
    assign sum_wide = {1'b0, acc_q} + {1'b0, part_ext};
    assign sum      = sum_wide[ACC_W] ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
`else
    assign sum = acc_q + part_ext;
`endif

    assign act_o = (sum >= thr_i);

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (take_i) begin
            acc_d = last_i ? '0 : sum;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/bnn_popcount_accum.sv
// BNN popcount accumulator top: chunk counter, activation bit packer and
// ACCUM/HOLD output handshake. Honours macro BNN_ACC_SAT_EN via bnn_accum_unit.
module bnn_popcount_accum
    import bnn_popcount_accum_pkg::*;
#(
    parameter int CHUNKS = 4,
    parameter int ACC_W  = BNN_ACC_W_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [BNN_PART_W-1:0] in_data,
    input  logic [ACC_W-1:0]      thr,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [BNN_PACK_W-1:0] out_data
);

    localparam int CNT_W = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(CHUNKS - 1);

    logic [0:0]            state_q, state_d;
    logic [CNT_W-1:0]      chunk_cnt_q, chunk_cnt_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [BNN_PACK_W-1:0] shreg_q, shreg_d;
    logic [BNN_PACK_W-1:0] out_data_q, out_data_d;
    logic [BNN_PACK_W-1:0] byte_nxt;
    logic                  take;
    logic                  last_chunk;
    logic                  act_bit;

    assign in_ready   = (state_q == ST_ACCUM);
    assign out_valid  = (state_q == ST_HOLD);
    assign out_data   = out_data_q;
    assign take       = in_valid & in_ready;
    assign last_chunk = (chunk_cnt_q == LAST_CHUNK);

    bnn_accum_unit #(
        .ACC_W (ACC_W)
    ) u_accum (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (clr),
        .take_i (take),
        .last_i (last_chunk),
        .part_i (in_data),
        .thr_i  (thr),
        .act_o  (act_bit)
    );

    // Soft clear has priority over both the handshake and an incoming partial.
    always_comb begin
        state_d           = state_q;
        chunk_cnt_d       = chunk_cnt_q;
        bit_cnt_d         = bit_cnt_q;
        shreg_d           = shreg_q;
        out_data_d        = out_data_q;
        byte_nxt          = shreg_q;
        byte_nxt[bit_cnt_q] = act_bit;

        if (clr) begin
            state_d     = ST_ACCUM;
            chunk_cnt_d = '0;
            bit_cnt_d   = '0;
            shreg_d     = '0;
        end else if (state_q == ST_HOLD) begin
            if (out_ready) begin
                state_d   = ST_ACCUM;
                bit_cnt_d = '0;
                shreg_d   = '0;
            end
        end else if (take) begin
            if (last_chunk) begin
                chunk_cnt_d = '0;
                shreg_d     = byte_nxt;
                bit_cnt_d   = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    out_data_d = byte_nxt;
                    state_d    = ST_HOLD;
                end
            end else begin
                chunk_cnt_d = chunk_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ACCUM;
            chunk_cnt_q <= '0;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            chunk_cnt_q <= chunk_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            out_data_q  <= out_data_d;
        end
    end

endmodule
